mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: MISS_CNT_WIDTH, 32, width of miss event/cycle counters.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 stall_mem_i  in  1  hold EX-MEM register.
REQ-005 clear_mem_i  in  1  flush EX-MEM register (bubble).
REQ-006 pc_ex_i  in  32  PC of EX instruction.
REQ-007 mem_req_i, mem_we_i  in  1 each  EX memory request / write.
REQ-008 mem_type_i  in  3  funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 alu_result_i  in  32  address or ALU result.
REQ-010 rs2_data_i  in  32  raw store data.
REQ-011 regfile_waddr_i  in  5; regfile_we_i  in  1; regfile_wr_mux_i  in  WB_WR_MUX_OP_WIDTH.
REQ-012 miss_i  in  1  data-cache miss from downstream WB stage.
REQ-013 pc_mem_o  out  32; mem_req_o, mem_we_o  out  1; mem_be_o  out  4; mem_type_o  out  3; mem_addr_o  out  32; mem_wdata_o  out  32: request to WB stage.
REQ-014 regfile_waddr_o  out  5; regfile_wdata_o  out  32; regfile_we_o  out  1; regfile_wr_mux_o  out  WB_WR_MUX_OP_WIDTH.
REQ-015 misalign_o  out  1  registered instruction is misaligned access.
REQ-016 stall_req_o  out  1  pipeline stall request to hazard unit.
REQ-017 miss_evt_o, miss_cyc_o  out  MISS_CNT_WIDTH each  miss counters.

Function
REQ-018 EX-MEM register SHALL load all EX inputs on rising clk when ~stall_mem_i and ~clear_mem_i; hold when stall_mem_i.
REQ-019 clear_mem_i SHALL win over stall_mem_i; clear zeroes all fields except pc_mem_o.
REQ-020 mem_addr_o and regfile_wdata_o SHALL both equal registered alu_result; pc_mem_o registered pc_ex_i.
REQ-021 mem_be_o SHALL decode from mem_type[1:0] and addr[1:0]: B -> 4'b0001 << addr[1:0]; H -> 4'b0011 << {addr[1],0}; W -> 4'b1111.
REQ-022 mem_wdata_o SHALL replicate store data into lanes: B -> {4{rs2[7:0]}}; H -> {2{rs2[15:0]}}; W -> rs2.
REQ-023 misalign_o SHALL be 1 when mem_req registered and (H with addr[0]=1, or W with addr[1:0]!=0).
REQ-024 Misaligned access SHALL force mem_req_o=0, mem_be_o=0, regfile_we_o=0; other outputs unchanged.
REQ-025 FSM states IDLE, MISS_WAIT; IDLE->MISS_WAIT when miss_i=1; MISS_WAIT->IDLE when miss_i=0; no other transitions.
REQ-026 stall_req_o SHALL equal miss_i combinationally (same-cycle), in both states.
REQ-027 miss_evt_o SHALL increment by 1 on each IDLE->MISS_WAIT transition; miss_cyc_o SHALL increment every cycle miss_i=1.
REQ-028 Counters SHALL saturate at all-ones, never wrap.
REQ-029 All outputs combinationally derived from registered state only, except stall_req_o.

Reset
REQ-030 rst_n=0 SHALL immediately zero EX-MEM fields (pc_mem_o included), misalign_o, counters, FSM->IDLE.
REQ-031 Reset during MISS_WAIT SHALL abort wait; counters read 0 first cycle after release.

Configuration
REQ-032 Macro MEM_MISS_CNT_EN: defined -> REQ-027/028 counters implemented; undefined -> miss_evt_o and miss_cyc_o tied 0, FSM still drives stall_req_o.

Verification
REQ-033 SB, alu_result=0x1002, rs2=0xA5 -> mem_be_o=4'b0100, mem_wdata_o=0xA5A5A5A5, mem_req_o=1, misalign_o=0.
REQ-034 LW addr=0x1006 -> misalign_o=1, mem_req_o=0, regfile_we_o=0, mem_be_o=0.
REQ-035 stall_mem_i=1 and clear_mem_i=1 same cycle with valid SW in EX -> next cycle mem_req_o=0, regfile_we_o=0.
REQ-036 miss_i high 3 cycles, low 1, high 2 (MEM_MISS_CNT_EN) -> miss_evt_o=2, miss_cyc_o=5, stall_req_o tracks miss_i.
REQ-037 MISS_CNT_WIDTH=4, 20 miss cycles -> miss_cyc_o=15 held.
REQ-038 rst_n low mid MISS_WAIT -> all outputs 0 asynchronously, FSM IDLE after release.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: EX-MEM pipeline register plus memory request shaping.
//   - Byte-enable decode and store-lane replication from the registered access.
//   - Misaligned halfword/word accesses are killed (no request, no enables,
//     no register write) and flagged on misalign_o.
//   - Two-state miss tracker forwards miss_i to the hazard unit as a stall.
//   - Optional saturating miss counters, built only when MEM_MISS_CNT_EN is
//     defined; otherwise miss_evt_o / miss_cyc_o are tied to zero.
module mem_stage #(
  parameter int MISS_CNT_WIDTH     = 32,
  parameter int WB_WR_MUX_OP_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall_mem_i,
  input  logic                          clear_mem_i,
  input  logic [31:0]                   pc_ex_i,
  input  logic                          mem_req_i,
  input  logic                          mem_we_i,
  input  logic [2:0]                    mem_type_i,
  input  logic [31:0]                   alu_result_i,
  input  logic [31:0]                   rs2_data_i,
  input  logic [4:0]                    regfile_waddr_i,
  input  logic                          regfile_we_i,
  input  logic [WB_WR_MUX_OP_WIDTH-1:0] regfile_wr_mux_i,
  input  logic                          miss_i,
  output logic [31:0]                   pc_mem_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [3:0]                    mem_be_o,
  output logic [2:0]                    mem_type_o,
  output logic [31:0]                   mem_addr_o,
  output logic [31:0]                   mem_wdata_o,
  output logic [4:0]                    regfile_waddr_o,
  output logic [31:0]                   regfile_wdata_o,
  output logic                          regfile_we_o,
  output logic [WB_WR_MUX_OP_WIDTH-1:0] regfile_wr_mux_o,
  output logic                          misalign_o,
  output logic                          stall_req_o,
  output logic [MISS_CNT_WIDTH-1:0]     miss_evt_o,
  output logic [MISS_CNT_WIDTH-1:0]     miss_cyc_o
);

  typedef enum logic {IDLE, MISS_WAIT} state_t;

  logic [31:0]                   pc_q;
  logic                          req_q;
  logic                          we_q;
  logic [2:0]                    type_q;
  logic [31:0]                   alu_q;
  logic [31:0]                   rs2_q;
  logic [4:0]                    waddr_q;
  logic                          rfwe_q;
  logic [WB_WR_MUX_OP_WIDTH-1:0] wrmux_q;

  logic [1:0] size;
  logic [1:0] addr_lo;
  logic [3:0] be_raw;
  logic       misalign;

  state_t state, state_nxt;

  // PC is not part of the bubble: it follows stall only, so a flushed slot
  // still carries the PC of the instruction it replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pc_q <= '0;
    else if (!stall_mem_i) pc_q <= pc_ex_i;
  end

  // EX-MEM payload: clear beats stall and inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear_mem_i) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      type_q  <= '0;
      alu_q   <= '0;
      rs2_q   <= '0;
      waddr_q <= '0;
      rfwe_q  <= 1'b0;
      wrmux_q <= '0;
    end else if (!stall_mem_i) begin
      req_q   <= mem_req_i;
      we_q    <= mem_we_i;
      type_q  <= mem_type_i;
      alu_q   <= alu_result_i;
      rs2_q   <= rs2_data_i;
      waddr_q <= regfile_waddr_i;
      rfwe_q  <= regfile_we_i;
      wrmux_q <= regfile_wr_mux_i;
    end
  end

  assign size    = type_q[1:0];
  assign addr_lo = alu_q[1:0];

  // Byte enables and store-lane replication from the registered access size.
  always_comb begin
    be_raw      = 4'b0000;
    mem_wdata_o = rs2_q;
    case (size)
      2'b00: begin
        be_raw      = 4'b0001 << addr_lo;
        mem_wdata_o = {4{rs2_q[7:0]}};
      end
      2'b01: begin
        be_raw      = 4'b0011 << {addr_lo[1], 1'b0};
        mem_wdata_o = {2{rs2_q[15:0]}};
      end
      2'b10: begin
        be_raw      = 4'b1111;
        mem_wdata_o = rs2_q;
      end
      default: begin
        be_raw      = 4'b0000;
        mem_wdata_o = rs2_q;
      end
    endcase
  end

  assign misalign = req_q && (((size == 2'b01) && addr_lo[0]) ||
                              ((size == 2'b10) && (addr_lo != 2'b00)));

  assign pc_mem_o         = pc_q;
  assign misalign_o       = misalign;
  assign mem_req_o        = req_q && !misalign;
  // Enables only accompany a live request so an idle slot drives all zeros.
  assign mem_be_o         = mem_req_o ? be_raw : 4'b0000;
  assign mem_we_o         = we_q;
  assign mem_type_o       = type_q;
  assign mem_addr_o       = alu_q;
  assign regfile_wdata_o  = alu_q;
  assign regfile_waddr_o  = waddr_q;
  assign regfile_we_o     = rfwe_q && !misalign;
  assign regfile_wr_mux_o = wrmux_q;

  // Miss tracker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Miss tracker next state; the stall request is miss_i passed straight through.
  always_comb begin
    state_nxt   = state;
    stall_req_o = miss_i;
    case (state)
      IDLE:      if (miss_i)  state_nxt = MISS_WAIT;
      MISS_WAIT: if (!miss_i) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

`ifdef MEM_MISS_CNT_EN
  logic                      evt_inc;
  logic [MISS_CNT_WIDTH-1:0] evt_q;
  logic [MISS_CNT_WIDTH-1:0] cyc_q;

  assign evt_inc = (state == IDLE) && miss_i;

  // Saturating miss counters: events on entering MISS_WAIT, cycles while missing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
      cyc_q <= '0;
    end else begin
      if (evt_inc && (evt_q != {MISS_CNT_WIDTH{1'b1}})) evt_q <= evt_q + 1'b1;
      if (miss_i  && (cyc_q != {MISS_CNT_WIDTH{1'b1}})) cyc_q <= cyc_q + 1'b1;
    end
  end

  assign miss_evt_o = evt_q;
  assign miss_cyc_o = cyc_q;
`else
  assign miss_evt_o = '0;
  assign miss_cyc_o = '0;
`endif

endmodule
